// File: rtl/vic20_loader_pkg.sv
// vic20_loader_pkg: constants and types shared by VIC-20 download loaders.
package vic20_loader_pkg;
  localparam logic [15:0] INJ_ADDR [8] = '{16'h002D, 16'h002E, 16'h002F, 16'h0030,
                                           16'h0031, 16'h0032, 16'h00AE, 16'h00AF};
  localparam logic [15:0] RAM_LO_END  = 16'h0400;
  localparam logic [15:0] RAM_HI_BASE = 16'h1000;
  localparam logic [15:0] RAM_HI_END  = 16'h2000;
  localparam logic [15:0] COLOR_BASE  = 16'h9400;
  localparam logic [15:0] COLOR_END   = 16'h9800;
  localparam logic [15:0] KERNAL_BASE = 16'hE000;
  localparam logic [15:0] BASIC_BASE  = 16'hC000;
  localparam logic [15:0] CHAR_BASE   = 16'h8000;
  typedef enum logic [4:0] {INJ_S[32]} inj_state_t;
endpackage

// File: rtl/vic20_prg_loader_if.sv
// vic20_prg_loader_if: data_io download stream in, VIC-20 memory write port out.
interface vic20_prg_loader_if;
  logic ioctl_download, ioctl_wr, crt_no_hdr, mem_wr_int, mem_wr_ext, force_reset, busy;
  logic [7:0] ioctl_index, ioctl_dout, mem_data;
  logic [15:0] ioctl_addr, mem_addr;
  modport master (output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, crt_no_hdr,
                  input mem_addr, mem_data, mem_wr_int, mem_wr_ext, force_reset, busy);
  modport slave (input ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, crt_no_hdr,
                 output mem_addr, mem_data, mem_wr_int, mem_wr_ext, force_reset, busy);
endinterface

// File: rtl/vic20_mem_decode.sv
// vic20_mem_decode: ROM image routing and internal/external target classification.
module vic20_mem_decode
  import vic20_loader_pkg::*;
(
  input  logic [15:0] rom_off_i,
  input  logic [15:0] tgt_i,
  output logic [15:0] rom_addr_o,
  output logic        rom_ok_o,
  output logic        is_int_o
);
  always_comb begin
    rom_ok_o = rom_off_i[15:13] inside {3'b010, 3'b011, 3'b100};
    rom_addr_o = rom_off_i[15:13] == 3'b010 ? {KERNAL_BASE[15:13], rom_off_i[12:0]}
               : rom_off_i[15:13] == 3'b011 ? {BASIC_BASE[15:13], rom_off_i[12:0]}
               : {CHAR_BASE[15:12], rom_off_i[11:0]};
    is_int_o = (tgt_i < RAM_LO_END) | (tgt_i >= RAM_HI_BASE & tgt_i < RAM_HI_END)
             | (tgt_i >= COLOR_BASE & tgt_i < COLOR_END);
  end
endmodule

// File: rtl/vic20_prg_loader.sv
// vic20_prg_loader: data_io byte stream to VIC-20 memory writes plus BASIC end-pointer injection.
// `define VIC20_CRT_AUTORESET_EN to request a reset after a cartridge lands at CART_BASE.
module vic20_prg_loader
  import vic20_loader_pkg::*;
#(
  parameter logic [15:0] CART_BASE  = 16'hA000,
  parameter int unsigned INJECT_LEN = 31
) (
  input logic clk_sys,
  input logic reset_n,
  vic20_prg_loader_if.slave bus
);
  localparam logic [4:0] INJ_LAST = 5'(INJECT_LEN);
  inj_state_t inj_q, inj_d;
  logic [15:0] next_addr_q, next_addr_d, mem_addr_q, mem_addr_d, tgt, rom_tgt;
  logic [7:0] mem_data_q, mem_data_d;
  logic wr_int_q, wr_int_d, wr_ext_q, wr_ext_d, busy_q, busy_d, prg_q, dl_q;
  logic rom, prg, wr, hdr, w, fall, abort, inj_wr, inj_last, rom_ok, is_int;
  vic20_mem_decode u_dec (
    .rom_off_i (bus.ioctl_addr),
    .tgt_i     (tgt),
    .rom_addr_o(rom_tgt),
    .rom_ok_o  (rom_ok),
    .is_int_o  (is_int)
  );
  always_comb begin
    rom = bus.ioctl_download & (bus.ioctl_index == 8'd0);
    prg = bus.ioctl_download & (bus.ioctl_index != 8'd0);
    wr = bus.ioctl_download & bus.ioctl_wr;
    hdr = (bus.ioctl_index[4:0] == 5'd1) | ~bus.crt_no_hdr;
    tgt = (!hdr && bus.ioctl_addr == 16'd0) ? CART_BASE : next_addr_q;
    w = prg & wr & (~hdr | (bus.ioctl_addr > 16'd1));
    fall = prg_q & ~prg;
    abort = bus.ioctl_download & ~dl_q & (inj_q != INJ_S0);
    inj_last = inj_q == INJ_LAST;
    inj_wr = inj_q[0] & ~inj_q[4] & ~abort;
    inj_d = abort ? INJ_S0 : fall ? INJ_S1 : (inj_q == INJ_S0 || inj_last) ? INJ_S0
          : inj_state_t'(inj_q + 5'd1);
    next_addr_d = (prg & wr & hdr & (bus.ioctl_addr == 16'd0)) ? {next_addr_q[15:8], bus.ioctl_dout}
                : (prg & wr & hdr & (bus.ioctl_addr == 16'd1)) ? {bus.ioctl_dout, next_addr_q[7:0]}
                : w ? tgt + 16'd1 : next_addr_q;
    wr_int_d = (rom & wr & rom_ok) | (w & is_int) | inj_wr;
    wr_ext_d = w & ~is_int;
    mem_addr_d = inj_wr ? INJ_ADDR[inj_q[3:1]] : rom ? rom_tgt : tgt;
    // no writes land during injection, so next_addr still holds the end pointer
    mem_data_d = !inj_wr ? bus.ioctl_dout : inj_q[1] ? next_addr_q[15:8] : next_addr_q[7:0];
    busy_d = bus.ioctl_download | (inj_d != INJ_S0);
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      inj_q <= INJ_S0;
      {next_addr_q, mem_addr_q, mem_data_q} <= '0;
      {wr_int_q, wr_ext_q, busy_q, prg_q, dl_q} <= '0;
    end else begin
      inj_q <= inj_d;
      {next_addr_q, mem_addr_q, mem_data_q} <= {next_addr_d, mem_addr_d, mem_data_d};
      {wr_int_q, wr_ext_q, busy_q, prg_q, dl_q} <= {wr_int_d, wr_ext_d, busy_d, prg, bus.ioctl_download};
    end
`ifdef VIC20_CRT_AUTORESET_EN
  logic auto_rst_q, auto_rst_d, force_q, force_d;
  always_comb begin
    auto_rst_d = (abort | inj_last) ? 1'b0 : (w && tgt == CART_BASE) ? 1'b1 : auto_rst_q;
    force_d = inj_last & auto_rst_q & ~abort;
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) {auto_rst_q, force_q} <= '0;
    else {auto_rst_q, force_q} <= {auto_rst_d, force_d};
  assign bus.force_reset = force_q;
`else
  assign bus.force_reset = 1'b0;
`endif
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_wr_int = wr_int_q;
  assign bus.mem_wr_ext = wr_ext_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_vic20_prg_loader.sv
// tb_vic20_prg_loader: scoreboard bench for the VIC-20 download loader.
module tb_vic20_prg_loader;
  typedef struct packed {logic ext; logic [15:0] a; logic [7:0] d;} wr_t;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  vic20_prg_loader_if bus();
  vic20_prg_loader dut (.clk_sys(clk), .reset_n(reset_n), .bus(bus));
  wr_t exp_q[$];
  wr_t mon_e;
  int checks = 0, passes = 0, n_force = 0;
  logic [15:0] inj_tab [8] = '{16'h002D, 16'h002E, 16'h002F, 16'h0030, 16'h0031, 16'h0032, 16'h00AE, 16'h00AF};
`ifdef VIC20_CRT_AUTORESET_EN
  int exp_force = 1;
`else
  int exp_force = 0;
`endif
  always @(negedge clk) begin
    if (bus.force_reset) n_force++;
    if (bus.mem_wr_int | bus.mem_wr_ext) begin
      checks++;
      if (exp_q.size() == 0)
        $display("FAIL unexpected_write int=%b ext=%b addr=%h data=%h required no write", bus.mem_wr_int, bus.mem_wr_ext, bus.mem_addr, bus.mem_data);
      else begin
        mon_e = exp_q.pop_front();
        if ({bus.mem_wr_ext, bus.mem_wr_int, bus.mem_addr, bus.mem_data} !== {mon_e.ext, ~mon_e.ext, mon_e.a, mon_e.d})
          $display("FAIL write ext=%b int=%b addr=%h data=%h required ext=%b int=%b addr=%h data=%h",
                   bus.mem_wr_ext, bus.mem_wr_int, bus.mem_addr, bus.mem_data, mon_e.ext, ~mon_e.ext, mon_e.a, mon_e.d);
        else passes++;
      end
    end
  end
  function automatic logic model_int(input logic [15:0] a);
    return (a < 16'h0400) || (a[15:12] == 4'h1) || (a[15:10] == 6'b100101);
  endfunction
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic strobe(input logic [15:0] a, input logic [7:0] d);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = a; bus.ioctl_dout = d;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
  endtask
  task automatic start_dl(input logic [7:0] idx);
    bus.ioctl_index = idx; bus.ioctl_download = 1'b1;
    @(negedge clk);
  endtask
  task automatic push(input logic ext, input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({ext, a, d});
  endtask
  task automatic push_inj(input logic [15:0] ep);
    for (int i = 0; i < 8; i++) push(1'b0, inj_tab[i], i[0] ? ep[15:8] : ep[7:0]);
  endtask
  task automatic load(input logic [7:0] idx, input logic [15:0] base, input int n, input logic [7:0] seed);
    logic [15:0] a;
    start_dl(idx);
    strobe(16'd0, base[7:0]);
    strobe(16'd1, base[15:8]);
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      push(!model_int(a), a, seed + 8'(i));
      strobe(16'(i + 2), seed + 8'(i));
    end
    bus.ioctl_download = 1'b0;
    push_inj(base + 16'(n));
    idle(40);
  endtask
  task automatic test_reset;
    bus.ioctl_download = 1'b1;
    idle(3);
    checks++;
    if ({bus.mem_addr, bus.mem_data, bus.mem_wr_int, bus.mem_wr_ext, bus.force_reset, bus.busy} !== '0)
      $display("FAIL reset_outputs addr=%h data=%h int=%b ext=%b force=%b busy=%b required all 0",
               bus.mem_addr, bus.mem_data, bus.mem_wr_int, bus.mem_wr_ext, bus.force_reset, bus.busy);
    else passes++;
    bus.ioctl_download = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(3);
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL idle_busy got %b required 0", bus.busy); else passes++;
  endtask
  task automatic test_rom;
    start_dl(8'd0);
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL rom_busy got %b required 1", bus.busy); else passes++;
    push(1'b0, 16'hE000, 8'hAA);
    strobe(16'h4000, 8'hAA);
    checks++;
    if ({bus.mem_wr_int, bus.mem_addr, bus.mem_data} !== {1'b1, 16'hE000, 8'hAA})
      $display("FAIL rom_latency int=%b addr=%h data=%h required 1 e000 aa", bus.mem_wr_int, bus.mem_addr, bus.mem_data);
    else passes++;
    strobe(16'h0000, 8'h55);
    checks++;
    if ({bus.mem_wr_int, bus.mem_wr_ext} !== 2'b00)
      $display("FAIL rom_1541_dropped int=%b ext=%b required 0 0", bus.mem_wr_int, bus.mem_wr_ext);
    else passes++;
    push(1'b0, 16'hC123, 8'h5A);
    strobe(16'h6123, 8'h5A);
    push(1'b0, 16'h8456, 8'h77);
    strobe(16'h8456, 8'h77);
    strobe(16'hA000, 8'h11);
    strobe(16'h2000, 8'h22);
    bus.ioctl_download = 1'b0;
    idle(4);
    checks++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0)
      $display("FAIL rom_done pending=%0d busy=%b required 0 0", exp_q.size(), bus.busy);
    else passes++;
    exp_q.delete();
  endtask
  task automatic test_prg;
    n_force = 0;
    bus.crt_no_hdr = 1'b0;
    start_dl(8'd1);
    strobe(16'd0, 8'h01);
    strobe(16'd1, 8'h12);
    push(1'b0, 16'h1201, 8'h11);
    strobe(16'd2, 8'h11);
    push(1'b0, 16'h1202, 8'h22);
    strobe(16'd3, 8'h22);
    push(1'b0, 16'h1203, 8'h33);
    strobe(16'd4, 8'h33);
    bus.ioctl_download = 1'b0;
    push_inj(16'h1204);
    idle(2);
    checks++;
    if ({bus.mem_wr_int, bus.mem_addr, bus.mem_data, bus.busy} !== {1'b1, 16'h002D, 8'h04, 1'b1})
      $display("FAIL inj_first int=%b addr=%h data=%h busy=%b required 1 002d 04 1", bus.mem_wr_int, bus.mem_addr, bus.mem_data, bus.busy);
    else passes++;
    idle(38);
    checks++;
    if (exp_q.size() != 0 || n_force != 0 || bus.busy !== 1'b0)
      $display("FAIL prg_done pending=%0d force=%0d busy=%b required 0 0 0", exp_q.size(), n_force, bus.busy);
    else passes++;
    exp_q.delete();
  endtask
  task automatic test_headerless;
    n_force = 0;
    bus.crt_no_hdr = 1'b1;
    start_dl(8'd2);
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 16'hA000 + 16'(i), 8'(16 * (i + 1)));
      strobe(16'(i), 8'(16 * (i + 1)));
    end
    bus.ioctl_download = 1'b0;
    push_inj(16'hA004);
    idle(40);
    checks++;
    if (exp_q.size() != 0) $display("FAIL crt_pending got %0d required 0", exp_q.size()); else passes++;
    checks++;
    if (n_force != exp_force) $display("FAIL crt_force_pulses got %0d required %0d", n_force, exp_force); else passes++;
    exp_q.delete();
    bus.crt_no_hdr = 1'b0;
  endtask
  task automatic test_decode;
    n_force = 0;
    load(8'd1, 16'h9400, 2, 8'hAB);
    load(8'd3, 16'h2000, 1, 8'hEE);
    load(8'd1, 16'h03FF, 2, 8'h01);
    load(8'd1, 16'h97FF, 2, 8'h40);
    load(8'd1, 16'hFFFF, 2, 8'h03);
    checks++;
    if (exp_q.size() != 0 || n_force != 0)
      $display("FAIL decode_done pending=%0d force=%0d required 0 0", exp_q.size(), n_force);
    else passes++;
    exp_q.delete();
  endtask
  task automatic test_abort;
    logic ok;
    n_force = 0;
    ok = 1'b1;
    start_dl(8'd1);
    strobe(16'd0, 8'h00);
    strobe(16'd1, 8'hA0);
    push(1'b1, 16'hA000, 8'h5A);
    strobe(16'd2, 8'h5A);
    bus.ioctl_download = 1'b0;
    push(1'b0, 16'h002D, 8'h01);
    push(1'b0, 16'h002E, 8'hA0);
    repeat (5) begin @(negedge clk); ok &= bus.busy; end
    bus.ioctl_index = 8'd0;
    bus.ioctl_download = 1'b1;
    repeat (8) begin @(negedge clk); ok &= bus.busy; end
    bus.ioctl_download = 1'b0;
    idle(40);
    checks++;
    if (ok !== 1'b1) $display("FAIL abort_busy got %b required 1", ok); else passes++;
    checks++;
    if (exp_q.size() != 0 || n_force != 0)
      $display("FAIL abort_done pending=%0d force=%0d required 0 0", exp_q.size(), n_force);
    else passes++;
    exp_q.delete();
    load(8'd1, 16'h3000, 1, 8'h77);
    checks++;
    if (exp_q.size() != 0 || n_force != 0)
      $display("FAIL abort_autorst_cleared pending=%0d force=%0d required 0 0", exp_q.size(), n_force);
    else passes++;
    exp_q.delete();
  endtask
  task automatic test_reset_mid;
    n_force = 0;
    bus.crt_no_hdr = 1'b1;
    start_dl(8'd2);
    push(1'b1, 16'hA000, 8'h21);
    strobe(16'd0, 8'h21);
    push(1'b1, 16'hA001, 8'h22);
    strobe(16'd1, 8'h22);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 16'd2; bus.ioctl_dout = 8'h23;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_addr, bus.mem_data, bus.mem_wr_int, bus.mem_wr_ext, bus.force_reset, bus.busy} !== '0)
      $display("FAIL reset_mid_outputs addr=%h data=%h int=%b ext=%b force=%b busy=%b required all 0",
               bus.mem_addr, bus.mem_data, bus.mem_wr_int, bus.mem_wr_ext, bus.force_reset, bus.busy);
    else passes++;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(40);
    checks++;
    if (exp_q.size() != 0 || n_force != 0 || bus.busy !== 1'b0)
      $display("FAIL reset_mid_no_inject pending=%0d force=%0d busy=%b required 0 0 0", exp_q.size(), n_force, bus.busy);
    else passes++;
    exp_q.delete();
    bus.crt_no_hdr = 1'b0;
  endtask
  initial begin
    bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = 16'd0; bus.ioctl_dout = 8'd0; bus.crt_no_hdr = 1'b0;
    @(negedge clk);
    test_reset;
    test_rom;
    test_prg;
    test_headerless;
    test_decode;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
